code_lock_fsm: RTL and testbench

CODE_LOCK_FSM -- requirements
Module: code_lock_fsm

---
 rtl/lock_pkg.sv | 17 +
 rtl/lock_timer.sv | 35 +++
 rtl/code_lock_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_code_lock_fsm.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the code lock: FSM state encoding and digit-counter width helper.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROG    = 3'd3,
    ST_LOCKOUT = 3'd4
  } lock_state_e;

  // Width needed to count 0..digits inclusive.
  function automatic int unsigned cnt_width(input int unsigned digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Lockout down-counter: load arms it, run counts down, done flags the final lockout cycle.
module lock_timer #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic done
);

  localparam int unsigned W = $clog2(CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(CYCLES - 1);
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = run && (cnt_q == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// Keypad code lock: digit entry, compare, open/relock, code programming and timed lockout.
module code_lock_fsm
  import lock_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DW          = 4,
  parameter int unsigned MAX_DIGIT   = 9,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter logic [DIGITS*DW-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            ent,
  input  logic                            change,
  input  logic [DW-1:0]                   sw,
  output logic                            unlocked,
  output logic                            prog_mode,
  output logic                            locked_out,
  output logic                            err,
  output logic                            bad_digit,
  output logic [cnt_width(DIGITS)-1:0]    digit_cnt,
  output logic [DIGITS*DW-1:0]            entry_buf,
  output logic [3:0]                      tries_left
);

  localparam int unsigned CW = cnt_width(DIGITS);
  localparam int unsigned BW = DIGITS * DW;

  lock_state_e   state_q, state_d;
  logic [BW-1:0] code_q, code_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tries_q, tries_d;
  logic          err_q, err_d;
  logic          bad_q, bad_d;
  logic          unlocked_q, unlocked_d;
  logic          prog_q, prog_d;
  logic          locked_q, locked_d;

  logic          legal;
  logic [BW-1:0] ins_buf;
  logic          timer_load;
  logic          timer_run;
  logic          timer_done;

  assign legal     = 32'(sw) <= MAX_DIGIT;
  assign timer_run = (state_q == ST_LOCKOUT);

  // Buffer with sw placed at the current digit position (digit 0 in the MSBs).
  always_comb begin
    ins_buf = buf_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        ins_buf[(DIGITS-1-i)*DW +: DW] = sw;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    tries_d    = tries_q;
    err_d      = err_q;
    bad_d      = 1'b0;
    timer_load = 1'b0;

    unique case (state_q)
      ST_ENTRY: begin
        if (clr) begin
          buf_d = '0;
          cnt_d = '0;
          err_d = 1'b0;
        end else if (cnt_q == CW'(DIGITS)) begin
          state_d = ST_CHECK;
        end else if (ent) begin
          if (legal) begin
            buf_d = ins_buf;
            cnt_d = cnt_q + CW'(1);
            err_d = 1'b0;
          end else begin
            bad_d = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == code_q) begin
          state_d = ST_OPEN;
          tries_d = 4'(MAX_TRIES);
          err_d   = 1'b0;
        end else begin
          err_d   = 1'b1;
          tries_d = tries_q - 4'd1;
          if (tries_q <= 4'd1) begin
            state_d    = ST_LOCKOUT;
            timer_load = 1'b1;
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end

      ST_OPEN: begin
        if (clr) begin
          state_d = ST_ENTRY;
        end else if (change) begin
          state_d = ST_PROG;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end

      ST_PROG: begin
        if (clr) begin
          state_d = ST_OPEN;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (ent) begin
          if (!legal) begin
            bad_d = 1'b1;
          end else if (cnt_q == CW'(DIGITS - 1)) begin
            // The final digit goes straight into the code register alongside the earlier ones.
            code_d  = ins_buf;
            state_d = ST_OPEN;
            buf_d   = '0;
            cnt_d   = '0;
          end else begin
            buf_d = ins_buf;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_LOCKOUT: begin
        if (timer_done) begin
          state_d = ST_ENTRY;
          tries_d = 4'(MAX_TRIES);
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_ENTRY;
        buf_d   = '0;
        cnt_d   = '0;
      end
    endcase

    unlocked_d = (state_d == ST_OPEN) || (state_d == ST_PROG);
    prog_d     = (state_d == ST_PROG);
    locked_d   = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ENTRY;
      code_q     <= DEFAULT_CODE;
      buf_q      <= '0;
      cnt_q      <= '0;
      tries_q    <= 4'(MAX_TRIES);
      err_q      <= 1'b0;
      bad_q      <= 1'b0;
      unlocked_q <= 1'b0;
      prog_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      tries_q    <= tries_d;
      err_q      <= err_d;
      bad_q      <= bad_d;
      unlocked_q <= unlocked_d;
      prog_q     <= prog_d;
      locked_q   <= locked_d;
    end
  end

  lock_timer #(
    .CYCLES (LOCK_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .run  (timer_run),
    .done (timer_done)
  );

  assign unlocked   = unlocked_q;
  assign prog_mode  = prog_q;
  assign locked_out = locked_q;
  assign err        = err_q;
  assign bad_digit  = bad_q;
  assign digit_cnt  = cnt_q;
  assign entry_buf  = buf_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: directed scenarios plus random pulses against a queue-based lock model.
module tb_code_lock_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        ent = 1'b0;
  logic        change = 1'b0;
  logic [3:0]  sw = '0;
  logic        unlocked, prog_mode, locked_out, err, bad_digit;
  logic [2:0]  digit_cnt;
  logic [15:0] entry_buf;
  logic [3:0]  tries_left;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  code_lock_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .ent        (ent),
    .change     (change),
    .sw         (sw),
    .unlocked   (unlocked),
    .prog_mode  (prog_mode),
    .locked_out (locked_out),
    .err        (err),
    .bad_digit  (bad_digit),
    .digit_cnt  (digit_cnt),
    .entry_buf  (entry_buf),
    .tries_left (tries_left)
  );

  // Reference model: mode name, stored code digits, digits typed so far, remaining tries.
  string m_mode;
  int    m_code[4];
  int    m_q[$];
  int    m_tries;
  bit    m_err;
  bit    m_bad;
  int    m_lock_left;

  function automatic void m_reset();
    m_mode      = "entry";
    m_code      = '{1, 2, 3, 4};
    m_q.delete();
    m_tries     = 3;
    m_err       = 1'b0;
    m_bad       = 1'b0;
    m_lock_left = 0;
  endfunction

  function automatic void m_step(input bit c, input bit e, input bit ch, input int s);
    bit match;
    m_bad = 1'b0;
    case (m_mode)
      "entry": begin
        if (c) begin
          m_q.delete();
          m_err = 1'b0;
        end else if (m_q.size() == 4) begin
          m_mode = "check";
        end else if (e) begin
          if (s <= 9) begin
            m_q.push_back(s);
            m_err = 1'b0;
          end else m_bad = 1'b1;
        end
      end
      "check": begin
        match = 1'b1;
        for (int i = 0; i < 4; i++) if (m_q[i] != m_code[i]) match = 1'b0;
        m_q.delete();
        if (match) begin
          m_mode  = "open";
          m_tries = 3;
          m_err   = 1'b0;
        end else begin
          m_err   = 1'b1;
          m_tries = m_tries - 1;
          if (m_tries == 0) begin
            m_mode      = "lockout";
            m_lock_left = 1024;
          end else m_mode = "entry";
        end
      end
      "open": begin
        if (c) m_mode = "entry";
        else if (ch) begin
          m_mode = "prog";
          m_q.delete();
        end
      end
      "prog": begin
        if (c) begin
          m_mode = "open";
          m_q.delete();
        end else if (e) begin
          if (s <= 9) begin
            m_q.push_back(s);
            if (m_q.size() == 4) begin
              for (int i = 0; i < 4; i++) m_code[i] = m_q[i];
              m_q.delete();
              m_mode = "open";
            end
          end else m_bad = 1'b1;
        end
      end
      "lockout": begin
        m_lock_left = m_lock_left - 1;
        if (m_lock_left == 0) begin
          m_mode  = "entry";
          m_tries = 3;
          m_err   = 1'b0;
        end
      end
      default: m_mode = "entry";
    endcase
  endfunction

  function automatic logic [27:0] m_outs();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < m_q.size(); i++) v[(3-i)*4 +: 4] = 4'(m_q[i]);
    return {m_mode == "open" || m_mode == "prog", m_mode == "prog", m_mode == "lockout",
            m_err, m_bad, 3'(m_q.size()), v, 4'(m_tries)};
  endfunction

  task automatic tick(input bit c, input bit e, input bit ch, input logic [3:0] s);
    clr = c; ent = e; change = ch; sw = s;
    @(posedge clk);
    m_step(c, e, ch, int'(s));
    #1;
    clr = 1'b0; ent = 1'b0; change = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] code);
    logic [15:0] v;
    v = code;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, v[(3-i)*4 +: 4]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL reset_unlocked got=%b want=0", unlocked); end
    total++; if (prog_mode !== 1'b0) begin bad++; $display("FAIL reset_prog got=%b want=0", prog_mode); end
    total++; if (locked_out !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked_out); end
    total++; if (err !== 1'b0 || bad_digit !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", err, bad_digit); end
    total++; if (digit_cnt !== 3'd0 || entry_buf !== 16'h0) begin bad++; $display("FAIL reset_buf got=%0d/%h want=0/0000", digit_cnt, entry_buf); end
    total++; if (tries_left !== 4'd3) begin bad++; $display("FAIL reset_tries got=%0d want=3", tries_left); end
  endtask

  task automatic test_correct_entry();
    enter4(16'h1234);
    total++; if (digit_cnt !== 3'd4 || entry_buf !== 16'h1234) begin bad++; $display("FAIL entry_buf got=%0d/%h want=4/1234", digit_cnt, entry_buf); end
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    total++; if (unlocked !== 1'b0 || digit_cnt !== 3'd4) begin bad++; $display("FAIL entry_check_cycle got=%b/%0d want=0/4", unlocked, digit_cnt); end
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    total++; if (unlocked !== 1'b1 || tries_left !== 4'd3) begin bad++; $display("FAIL entry_open got=%b/%0d want=1/3", unlocked, tries_left); end
    total++; if (digit_cnt !== 3'd0 || entry_buf !== 16'h0 || err !== 1'b0) begin bad++; $display("FAIL entry_open_clear got=%0d/%h/%b want=0/0000/0", digit_cnt, entry_buf, err); end
    tick(1'b0, 1'b1, 1'b0, 4'd5);
    total++; if (unlocked !== 1'b1 || digit_cnt !== 3'd0) begin bad++; $display("FAIL open_ent_ignored got=%b/%0d want=1/0", unlocked, digit_cnt); end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL relock got=%b want=0", unlocked); end
  endtask

  task automatic test_lockout();
    logic [3:0] want_tries;
    for (int a = 0; a < 3; a++) begin
      enter4(16'h0000);
      tick(1'b0, 1'b0, 1'b0, 4'd0);
      tick(1'b0, 1'b0, 1'b0, 4'd0);
      want_tries = 4'(2 - a);
      total++; if (tries_left !== want_tries || err !== 1'b1) begin bad++; $display("FAIL lockout_try%0d got=%0d/%b want=%0d/1", a, tries_left, err, want_tries); end
      total++; if (locked_out !== (a == 2) || unlocked !== 1'b0) begin bad++; $display("FAIL lockout_flag%0d got=%b/%b want=%b/0", a, locked_out, unlocked, a == 2); end
    end
    for (int k = 1; k <= 1024; k++) begin
      tick(k == 5, k <= 4, k == 6, 4'(k));
      if (k == 4) begin
        total++; if (digit_cnt !== 3'd0 || bad_digit !== 1'b0) begin bad++; $display("FAIL lockout_ent_ignored got=%0d/%b want=0/0", digit_cnt, bad_digit); end
      end
      if (k == 6) begin
        total++; if (locked_out !== 1'b1 || err !== 1'b1 || prog_mode !== 1'b0) begin bad++; $display("FAIL lockout_hold got=%b/%b/%b want=1/1/0", locked_out, err, prog_mode); end
      end
      if (k == 1023) begin
        total++; if (locked_out !== 1'b1) begin bad++; $display("FAIL lockout_last_cycle got=%b want=1", locked_out); end
      end
    end
    total++; if (locked_out !== 1'b0 || unlocked !== 1'b0) begin bad++; $display("FAIL lockout_exit got=%b/%b want=0/0", locked_out, unlocked); end
    total++; if (tries_left !== 4'd3 || err !== 1'b0) begin bad++; $display("FAIL lockout_restore got=%0d/%b want=3/0", tries_left, err); end
    enter4(16'h1234);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL lockout_then_open got=%b want=1", unlocked); end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_reprogram();
    enter4(16'h1234);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    total++; if (prog_mode !== 1'b1 || unlocked !== 1'b1) begin bad++; $display("FAIL prog_enter got=%b/%b want=1/1", prog_mode, unlocked); end
    enter4(16'h9876);
    total++; if (prog_mode !== 1'b0 || unlocked !== 1'b1 || digit_cnt !== 3'd0) begin bad++; $display("FAIL prog_done got=%b/%b/%0d want=0/1/0", prog_mode, unlocked, digit_cnt); end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    enter4(16'h1234);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0);
    total++; if (unlocked !== 1'b0 || err !== 1'b1 || tries_left !== 4'd2) begin bad++; $display("FAIL prog_old_rejected got=%b/%b/%0d want=0/1/2", unlocked, err, tries_left); end
    enter4(16'h9876);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0);
    total++; if (unlocked !== 1'b1 || tries_left !== 4'd3) begin bad++; $display("FAIL prog_new_opens got=%b/%0d want=1/3", unlocked, tries_left); end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_illegal_digit();
    tick(1'b0, 1'b1, 1'b0, 4'd1);
    tick(1'b0, 1'b1, 1'b0, 4'hA);
    total++; if (bad_digit !== 1'b1 || digit_cnt !== 3'd1) begin bad++; $display("FAIL illegal_pulse got=%b/%0d want=1/1", bad_digit, digit_cnt); end
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    total++; if (bad_digit !== 1'b0 || entry_buf !== 16'h1000) begin bad++; $display("FAIL illegal_one_cycle got=%b/%h want=0/1000", bad_digit, entry_buf); end
    tick(1'b1, 1'b1, 1'b0, 4'd5);
    total++; if (digit_cnt !== 3'd0 || entry_buf !== 16'h0) begin bad++; $display("FAIL clr_beats_ent got=%0d/%h want=0/0000", digit_cnt, entry_buf); end
  endtask

  task automatic test_abort_reset();
    do_reset();
    enter4(16'h1234);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    tick(1'b0, 1'b1, 1'b0, 4'd5);
    tick(1'b0, 1'b1, 1'b0, 4'd6);
    total++; if (digit_cnt !== 3'd2 || entry_buf !== 16'h5600) begin bad++; $display("FAIL prog_partial got=%0d/%h want=2/5600", digit_cnt, entry_buf); end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    total++; if (prog_mode !== 1'b0 || unlocked !== 1'b1 || digit_cnt !== 3'd0) begin bad++; $display("FAIL prog_abort got=%b/%b/%0d want=0/1/0", prog_mode, unlocked, digit_cnt); end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    enter4(16'h1234);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL abort_keeps_code got=%b want=1", unlocked); end
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (3) begin
      enter4(16'h0000);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0);
    end
    repeat (10) tick(1'b0, 1'b0, 1'b0, 4'd0);
    total++; if (locked_out !== 1'b1) begin bad++; $display("FAIL mid_lockout got=%b want=1", locked_out); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (locked_out !== 1'b0 || tries_left !== 4'd3 || err !== 1'b0) begin bad++; $display("FAIL async_reset got=%b/%0d/%b want=0/3/0", locked_out, tries_left, err); end
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    enter4(16'h1234);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 4'd0);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL reset_default_code got=%b want=1", unlocked); end
  endtask

  task automatic test_random();
    logic [27:0] got, exp;
    do_reset();
    for (int n = 0; n < 5000; n++) begin
      bit c, e, ch;
      int s;
      c  = ($urandom_range(0, 29) == 0);
      ch = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 2) != 0);
      if (m_mode == "entry" && m_q.size() == 4) e = 1'b0;
      if (m_mode == "entry" && m_q.size() < 4 && $urandom_range(0, 7) != 0) s = m_code[m_q.size()];
      else if (m_mode == "entry" || m_mode == "prog") s = $urandom_range(0, 15);
      else s = $urandom_range(0, 9);
      tick(c, e, ch, 4'(s));
      exp = m_outs();
      got = {unlocked, prog_mode, locked_out, err, bad_digit, digit_cnt, entry_buf, tries_left};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random_cycle%0d got=%h want=%h mode=%s", n, got, exp, m_mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct_entry();
    test_lockout();
    test_reprogram();
    test_illegal_digit();
    test_abort_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
